// File: rtl/game_pkg.sv
// Shared definitions for the 1P factorization game: state codes, field
// widths, the prime constants and the question table. The ready block's
// state decode imports this package as well.
package game_pkg;

    localparam int STATE_W = 4;
    localparam int VALUE_W = 7;
    localparam int SCORE_W = 3;
    localparam int LIFE_W  = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 4'b0000,
        ST_REQ  = 4'b0001,
        ST_WAIT = 4'b0010,
        ST_PLAY = 4'b0011,
        ST_DRAW = 4'b0110,
        ST_GOOD = 4'b1000,
        ST_OUCH = 4'b1001,
        ST_WIN  = 4'b1010,
        ST_LOSE = 4'b1011
    } state_e;

    localparam logic [VALUE_W-1:0] PRIME_2 = 7'd2;
    localparam logic [VALUE_W-1:0] PRIME_3 = 7'd3;
    localparam logic [VALUE_W-1:0] PRIME_5 = 7'd5;
    localparam logic [VALUE_W-1:0] PRIME_7 = 7'd7;

    // Question index to composite value; out-of-range indices fall back to 12.
    function automatic logic [VALUE_W-1:0] qtable(input logic [3:0] idx);
        logic [VALUE_W-1:0] q;
        case (idx)
            4'd0:    q = 7'd12;
            4'd1:    q = 7'd18;
            4'd2:    q = 7'd20;
            4'd3:    q = 7'd28;
            4'd4:    q = 7'd30;
            4'd5:    q = 7'd42;
            4'd6:    q = 7'd45;
            4'd7:    q = 7'd60;
            4'd8:    q = 7'd63;
            4'd9:    q = 7'd84;
            default: q = 7'd12;
        endcase
        return q;
    endfunction

    // Lowest set button wins: 0..3 selects prime 2, 3, 5, 7.
    function automatic logic [1:0] prime_idx(input logic [3:0] btn);
        logic [1:0] idx;
        if (btn[0])      idx = 2'd0;
        else if (btn[1]) idx = 2'd1;
        else if (btn[2]) idx = 2'd2;
        else             idx = 2'd3;
        return idx;
    endfunction

    // Divisibility by one of the four constant primes.
    function automatic logic divisible(input logic [VALUE_W-1:0] v, input logic [1:0] idx);
        logic ok;
        case (idx)
            2'd0:    ok = ((v % PRIME_2) == 7'd0);
            2'd1:    ok = ((v % PRIME_3) == 7'd0);
            2'd2:    ok = ((v % PRIME_5) == 7'd0);
            default: ok = ((v % PRIME_7) == 7'd0);
        endcase
        return ok;
    endfunction

    // Quotient by one of the four constant primes.
    function automatic logic [VALUE_W-1:0] div_prime(input logic [VALUE_W-1:0] v, input logic [1:0] idx);
        logic [VALUE_W-1:0] q;
        case (idx)
            2'd0:    q = v / PRIME_2;
            2'd1:    q = v / PRIME_3;
            2'd2:    q = v / PRIME_5;
            default: q = v / PRIME_7;
        endcase
        return q;
    endfunction

endpackage

// File: rtl/game_ctrl_sec_tick.sv
// One-second tick generator: counts DIV clocks and pulses tick for one
// cycle. A synchronous clear restarts the count so the first tick after a
// clear lands exactly DIV cycles later.
module sec_tick #(
    parameter int DIV = 50_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_r;

    // Free-running divider, restarted by reset or clear.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt_r <= CNT_W'(0);
        end else if (cnt_r == CNT_W'(DIV - 1)) begin
            cnt_r <= CNT_W'(0);
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick = (cnt_r == CNT_W'(DIV - 1));

endmodule

// File: rtl/game_ctrl.sv
// Round controller for the 1P factorization game: requests a question from
// the ready block, runs the prime-division moves, and tracks timeout,
// score, lives and the result-display holds.
module game_ctrl
    import game_pkg::*;
#(
    parameter int DIV        = 50_000_000,
    parameter int READY_LAT  = 3,
    parameter int TIME_LIMIT = 9,
    parameter int SHOW_SEC   = 1,
    parameter int WIN_SCORE  = 5,
    parameter int LIVES      = 3
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               BTN_START,
    input  logic [3:0]         BTN_P,
    input  logic               OK,
    input  logic [3:0]         NUM,
    output logic               READY_1P,
    output logic [STATE_W-1:0] STATE,
    output logic [VALUE_W-1:0] VALUE,
    output logic [SCORE_W-1:0] SCORE,
    output logic [LIFE_W-1:0]  LIFE
);
    localparam int WAIT_W  = (READY_LAT > 0) ? $clog2(READY_LAT + 1) : 1;
    localparam int SEC_MAX = (TIME_LIMIT > SHOW_SEC) ? TIME_LIMIT : SHOW_SEC;
    localparam int SEC_W   = $clog2(SEC_MAX + 1);

    state_e               state_r, state_nxt_s;
    logic                 entry_s, tick_s;
    logic [WAIT_W-1:0]    wait_cnt_r;
    logic [SEC_W-1:0]     sec_cnt_r;
    logic                 accept_s, press_s, div_ok_s, timeout_s, hold_done_s;
    logic [1:0]           prime_idx_s;
    logic [VALUE_W-1:0]   quot_s;
    logic [VALUE_W-1:0]   value_r, value_nxt_s;
    logic [SCORE_W-1:0]   score_r, score_nxt_s;
    logic [LIFE_W-1:0]    life_r, life_nxt_s;
    logic                 ready_r, ready_nxt_s;

    // Every state change restarts the tick divider and the second counter.
    assign entry_s = (state_nxt_s != state_r);

    sec_tick #(.DIV(DIV)) u_sec_tick (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (entry_s),
        .tick (tick_s)
    );

    // OK is sticky from the previous round, so only trust it from READY_LAT on.
    assign accept_s    = (wait_cnt_r == WAIT_W'(READY_LAT)) && OK;
    assign press_s     = (BTN_P != 4'b0000);
    assign prime_idx_s = prime_idx(BTN_P);
    assign div_ok_s    = divisible(value_r, prime_idx_s);
    assign quot_s      = div_prime(value_r, prime_idx_s);
    // The saturated-count term keeps a timeout pending when a press won the tie.
    assign timeout_s   = (sec_cnt_r >= SEC_W'(TIME_LIMIT)) ||
                         (tick_s && (sec_cnt_r == SEC_W'(TIME_LIMIT - 1)));
    assign hold_done_s = (sec_cnt_r >= SEC_W'(SHOW_SEC)) ||
                         (tick_s && (sec_cnt_r == SEC_W'(SHOW_SEC - 1)));

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; unknown codes fall back to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (BTN_START) state_nxt_s = ST_REQ;
                else           state_nxt_s = ST_IDLE;
            end
            ST_REQ:  state_nxt_s = ST_WAIT;
            ST_WAIT: begin
                if (accept_s) state_nxt_s = ST_PLAY;
                else          state_nxt_s = ST_WAIT;
            end
            ST_PLAY: begin
                if (press_s) begin
                    if (!div_ok_s)                  state_nxt_s = ST_OUCH;
                    else if (quot_s == VALUE_W'(1)) state_nxt_s = ST_GOOD;
                    else                            state_nxt_s = ST_PLAY;
                end else if (timeout_s) begin
                    state_nxt_s = ST_DRAW;
                end else begin
                    state_nxt_s = ST_PLAY;
                end
            end
            ST_GOOD, ST_OUCH, ST_DRAW: begin
                if (!hold_done_s)                         state_nxt_s = state_r;
                else if (score_r == SCORE_W'(WIN_SCORE))  state_nxt_s = ST_WIN;
                else if (life_r == LIFE_W'(0))            state_nxt_s = ST_LOSE;
                else                                      state_nxt_s = ST_REQ;
            end
            ST_WIN, ST_LOSE: begin
                if (BTN_START) state_nxt_s = ST_IDLE;
                else           state_nxt_s = state_r;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        value_nxt_s = value_r;
        score_nxt_s = score_r;
        life_nxt_s  = life_r;
        ready_nxt_s = (state_nxt_s == ST_REQ);
        case (state_r)
            ST_IDLE: begin
                if (BTN_START) begin
                    score_nxt_s = SCORE_W'(0);
                    life_nxt_s  = LIFE_W'(LIVES);
                end else begin
                    score_nxt_s = score_r;
                end
            end
            ST_WAIT: begin
                if (accept_s) value_nxt_s = qtable(NUM);
                else          value_nxt_s = value_r;
            end
            ST_PLAY: begin
                if (press_s && div_ok_s) begin
                    value_nxt_s = quot_s;
                    if ((quot_s == VALUE_W'(1)) && (score_r != {SCORE_W{1'b1}}))
                        score_nxt_s = score_r + SCORE_W'(1);
                    else
                        score_nxt_s = score_r;
                end else if (press_s) begin
                    if (life_r != LIFE_W'(0)) life_nxt_s = life_r - LIFE_W'(1);
                    else                      life_nxt_s = LIFE_W'(0);
                end else begin
                    value_nxt_s = value_r;
                end
            end
            default: value_nxt_s = value_r;
        endcase
    end

    // Wait counter: restarts on entry and saturates at READY_LAT.
    always_ff @(posedge CLK) begin
        if (RST || entry_s) begin
            wait_cnt_r <= WAIT_W'(0);
        end else if ((state_r == ST_WAIT) && (wait_cnt_r != WAIT_W'(READY_LAT))) begin
            wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Elapsed seconds in the current state, for timeout and display hold.
    always_ff @(posedge CLK) begin
        if (RST || entry_s) begin
            sec_cnt_r <= SEC_W'(0);
        end else if (tick_s && (sec_cnt_r != SEC_W'(SEC_MAX))) begin
            sec_cnt_r <= sec_cnt_r + SEC_W'(1);
        end else begin
            sec_cnt_r <= sec_cnt_r;
        end
    end

    // Output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            value_r <= VALUE_W'(0);
            score_r <= SCORE_W'(0);
            life_r  <= LIFE_W'(LIVES);
            ready_r <= 1'b0;
        end else begin
            value_r <= value_nxt_s;
            score_r <= score_nxt_s;
            life_r  <= life_nxt_s;
            ready_r <= ready_nxt_s;
        end
    end

    assign STATE    = state_r;
    assign VALUE    = value_r;
    assign SCORE    = score_r;
    assign LIFE     = life_r;
    assign READY_1P = ready_r;

endmodule
